// File: rtl/rob_queue_if.sv
// Reorder-buffer port bundle: allocation, CDB capture, operand lookup and commit.
// The master side is the issue/execute pipeline, the slave side is rob_queue.
interface rob_queue_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 4
);
    localparam int unsigned TAG_W = $clog2(DEPTH);

    // Allocation at issue
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_dest;
    logic              alloc_is_br;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;

    // Common data bus
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_mispred;

    // Operand lookup
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    // In-order retirement
    logic              commit_valid;
    logic              commit_wen;
    logic [REG_W-1:0]  commit_dest;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;
    logic              flush;
    logic [TAG_W:0]    count;

    modport master (
        output alloc_valid, alloc_dest, alloc_is_br,
        input  alloc_ready, alloc_tag,
        output cdb_valid, cdb_tag, cdb_data, cdb_mispred,
        output rd_tag,
        input  rd_ready, rd_data,
        input  commit_valid, commit_wen, commit_dest, commit_data, commit_tag,
        input  flush, count
    );

    modport slave (
        input  alloc_valid, alloc_dest, alloc_is_br,
        output alloc_ready, alloc_tag,
        input  cdb_valid, cdb_tag, cdb_data, cdb_mispred,
        input  rd_tag,
        output rd_ready, rd_data,
        output commit_valid, commit_wen, commit_dest, commit_data, commit_tag,
        output flush, count
    );
endinterface

// File: rtl/rob_queue.sv
// Parametrised reorder buffer: in-order allocation at the tail, out-of-order result
// capture from the CDB by tag, in-order retirement of one entry per cycle from the head,
// and combinational operand lookup by tag.
// Optional feature macro: ROB_FLUSH_EN -- a retiring mispredicted branch raises flush and
// empties the buffer. Without it flush is tied low and branches retire as plain non-writes.
module rob_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 4
) (
    input logic        clk1,
    input logic        rst,
    rob_queue_if.slave rob
);
    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
    localparam logic [TAG_W:0]   CNT_ONE = (TAG_W + 1)'(1);

    // Per-entry status flags, one bit per entry
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] is_br_q, is_br_d;
`ifdef ROB_FLUSH_EN
    logic [DEPTH-1:0] mispred_q, mispred_d;
`endif

    // Per-entry payload
    logic [REG_W-1:0]  dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Circular-queue pointers and occupancy
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic full;
    logic empty;
    logic alloc_ready;
    logic commit_valid;
    logic flush_int;
    logic do_alloc;
    logic do_commit;
    logic do_cdb;

    // count never exceeds DEPTH, and DEPTH is a power of two, so the top bit means full
    assign full  = count_q[TAG_W];
    assign empty = (count_q == '0);

    assign commit_valid = ~empty & busy_q[head_q] & done_q[head_q];

`ifdef ROB_FLUSH_EN
    assign flush_int = commit_valid & is_br_q[head_q] & mispred_q[head_q];
`else
    logic unused_cdb_mispred;
    assign unused_cdb_mispred = rob.cdb_mispred;
    assign flush_int = 1'b0;
`endif

    assign alloc_ready = ~full & ~flush_int;
    assign do_alloc    = rob.alloc_valid & alloc_ready;
    assign do_commit   = commit_valid;
    // Writes to idle entries (including the one being allocated now) are dropped
    assign do_cdb      = rob.cdb_valid & busy_q[rob.cdb_tag] & ~flush_int;

    // Issue-side and lookup outputs
    always_comb begin
        rob.alloc_ready = alloc_ready;
        rob.alloc_tag   = tail_q;
        rob.rd_ready    = busy_q[rob.rd_tag] & done_q[rob.rd_tag];
        rob.rd_data     = data_q[rob.rd_tag];
        rob.count       = count_q;
        rob.flush       = flush_int;
    end

    // Retirement outputs; payload is zeroed while nothing retires
    always_comb begin
        rob.commit_valid = commit_valid;
        rob.commit_wen   = commit_valid & ~is_br_q[head_q];
        rob.commit_tag   = head_q;
        rob.commit_dest  = commit_valid ? dest_q[head_q] : '0;
        rob.commit_data  = commit_valid ? data_q[head_q] : '0;
    end

    // Next-state for flags, pointers and occupancy
    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q;
        is_br_d   = is_br_q;
`ifdef ROB_FLUSH_EN
        mispred_d = mispred_q;
`endif
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (flush_int) begin
            busy_d    = '0;
            done_d    = '0;
            is_br_d   = '0;
`ifdef ROB_FLUSH_EN
            mispred_d = '0;
`endif
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else begin
            if (do_cdb) begin
                done_d[rob.cdb_tag] = 1'b1;
`ifdef ROB_FLUSH_EN
                mispred_d[rob.cdb_tag] = rob.cdb_mispred;
`endif
            end

            // Allocation is applied after the CDB so it wins on the tail entry
            if (do_alloc) begin
                busy_d[tail_q]  = 1'b1;
                done_d[tail_q]  = 1'b0;
                is_br_d[tail_q] = rob.alloc_is_br;
`ifdef ROB_FLUSH_EN
                mispred_d[tail_q] = 1'b0;
`endif
                tail_d = tail_q + TAG_ONE;
            end

            if (do_commit) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d = head_q + TAG_ONE;
            end

            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Flag, pointer and occupancy registers
    always_ff @(posedge clk1) begin
        if (rst) begin
            busy_q    <= '0;
            done_q    <= '0;
            is_br_q   <= '0;
`ifdef ROB_FLUSH_EN
            mispred_q <= '0;
`endif
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            is_br_q   <= is_br_d;
`ifdef ROB_FLUSH_EN
            mispred_q <= mispred_d;
`endif
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Payload storage: destination at allocation, result at CDB capture
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (do_cdb) begin
                data_q[rob.cdb_tag] <= rob.cdb_data;
            end
            if (do_alloc) begin
                dest_q[tail_q] <= rob.alloc_dest;
            end
        end
    end
endmodule

// File: tb/tb_rob_queue.sv
// Directed self-checking bench for rob_queue (DEPTH=8, DATA_W=16, REG_W=4).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_rob_queue;
    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rob_queue_if #(.DEPTH(8), .DATA_W(16), .REG_W(4)) bus ();

    rob_queue #(.DEPTH(8), .DATA_W(16), .REG_W(4)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .rob  (bus)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid = 1'b0;
        bus.alloc_dest  = '0;
        bus.alloc_is_br = 1'b0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        bus.cdb_mispred = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.rd_tag = '0;
        apply_reset();
        checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b want 1", bus.alloc_ready); end
        checks++; if (bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_alloc_tag: got %0d want 0", bus.alloc_tag); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.commit_valid !== 1'b0 || bus.commit_wen !== 1'b0) begin errors++; $display("FAIL reset_commit: got valid=%b wen=%b want 0/0", bus.commit_valid, bus.commit_wen); end
        checks++; if (bus.commit_data !== 16'h0 || bus.commit_dest !== 4'h0 || bus.commit_tag !== 3'd0) begin errors++; $display("FAIL reset_commit_payload: got data=%h dest=%h tag=%0d want 0/0/0", bus.commit_data, bus.commit_dest, bus.commit_tag); end
        checks++; if (bus.flush !== 1'b0 || bus.rd_ready !== 1'b0) begin errors++; $display("FAIL reset_flush_rd: got flush=%b rd_ready=%b want 0/0", bus.flush, bus.rd_ready); end
    endtask

    // Three allocations get tags 0,1,2 in program order
    task automatic test_alloc_order();
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_dest  = 4'(5 + i);
            #1;
            checks++; if (bus.alloc_tag !== 3'(i) || bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL alloc_tag_%0d: got tag=%0d ready=%b want %0d/1", i, bus.alloc_tag, bus.alloc_ready, i); end
            tick();
        end
        idle();
        #1;
        checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL alloc_count: got %0d want 3", bus.count); end
        checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL alloc_no_commit: got %b want 0", bus.commit_valid); end
    endtask

    // Results arrive 2,0,1 but retire 0,1,2 on consecutive cycles
    task automatic test_ooo_commit();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd2; bus.cdb_data = 16'h0022;
        tick();
        bus.cdb_tag = 3'd0; bus.cdb_data = 16'h0011;
        #1;
        checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_head_not_done: got %b want 0", bus.commit_valid); end
        tick();
        bus.cdb_tag = 3'd1; bus.cdb_data = 16'h0033;
        #1;
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 3'd0 || bus.commit_data !== 16'h0011 || bus.commit_dest !== 4'd5 || bus.commit_wen !== 1'b1) begin errors++; $display("FAIL ooo_commit0: got v=%b tag=%0d data=%h dest=%0d wen=%b want 1/0/0011/5/1", bus.commit_valid, bus.commit_tag, bus.commit_data, bus.commit_dest, bus.commit_wen); end
        tick();
        idle();
        #1;
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 3'd1 || bus.commit_data !== 16'h0033 || bus.commit_dest !== 4'd6) begin errors++; $display("FAIL ooo_commit1: got v=%b tag=%0d data=%h dest=%0d want 1/1/0033/6", bus.commit_valid, bus.commit_tag, bus.commit_data, bus.commit_dest); end
        tick();
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 3'd2 || bus.commit_data !== 16'h0022 || bus.commit_dest !== 4'd7) begin errors++; $display("FAIL ooo_commit2: got v=%b tag=%0d data=%h dest=%0d want 1/2/0022/7", bus.commit_valid, bus.commit_tag, bus.commit_data, bus.commit_dest); end
        tick();
        checks++; if (bus.count !== 4'd0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_drained: got count=%0d v=%b want 0/0", bus.count, bus.commit_valid); end
    endtask

    // Fill to DEPTH, try a ninth allocation, then commit with alloc_valid held high
    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_dest  = 4'(i);
            tick();
        end
        bus.alloc_dest = 4'd9;
        #1;
        checks++; if (bus.count !== 4'd8 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_state: got count=%0d ready=%b want 8/0", bus.count, bus.alloc_ready); end
        tick();
        checks++; if (bus.count !== 4'd8 || bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL full_ninth_ignored: got count=%0d tag=%0d want 8/0", bus.count, bus.alloc_tag); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd0; bus.cdb_data = 16'h0050;
        tick();
        bus.cdb_valid = 1'b0;
        #1;
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_data !== 16'h0050 || bus.commit_dest !== 4'd0 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_commit_ready: got v=%b data=%h dest=%0d ready=%b want 1/0050/0/0", bus.commit_valid, bus.commit_data, bus.commit_dest, bus.alloc_ready); end
        tick();
        idle();
        #1;
        checks++; if (bus.count !== 4'd7 || bus.alloc_tag !== 3'd0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL full_after_commit: got count=%0d tag=%0d v=%b want 7/0/0", bus.count, bus.alloc_tag, bus.commit_valid); end
    endtask

    // Twelve alloc/CDB/commit rounds; tags wrap from 7 back to 0
    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_dest  = 4'(i);
            #1;
            checks++; if (bus.alloc_tag !== 3'(i % 8)) begin errors++; $display("FAIL wrap_tag_%0d: got %0d want %0d", i, bus.alloc_tag, i % 8); end
            tick();
            idle();
            bus.cdb_valid = 1'b1; bus.cdb_tag = 3'(i % 8); bus.cdb_data = 16'(32'h0100 + i);
            tick();
            idle();
            #1;
            checks++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 3'(i % 8) || bus.commit_data !== 16'(32'h0100 + i) || bus.commit_dest !== 4'(i)) begin errors++; $display("FAIL wrap_commit_%0d: got v=%b tag=%0d data=%h dest=%0d want 1/%0d/%h/%0d", i, bus.commit_valid, bus.commit_tag, bus.commit_data, bus.commit_dest, i % 8, 16'(32'h0100 + i), i); end
            tick();
        end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL wrap_count: got %0d want 0", bus.count); end
    endtask

    // Branch at head resolved mispredicted
    task automatic test_branch();
        apply_reset();
        bus.alloc_valid = 1'b1; bus.alloc_is_br = 1'b1; bus.alloc_dest = 4'd3;
        tick();
        bus.alloc_is_br = 1'b0; bus.alloc_dest = 4'd4;
        tick();
        idle();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd0; bus.cdb_data = 16'h0000; bus.cdb_mispred = 1'b1;
        tick();
        bus.cdb_tag = 3'd1; bus.cdb_data = 16'h0077; bus.cdb_mispred = 1'b0;
        bus.alloc_valid = 1'b1; bus.alloc_dest = 4'd8;
        #1;
`ifdef ROB_FLUSH_EN
        checks++; if (bus.flush !== 1'b1 || bus.commit_valid !== 1'b1 || bus.commit_wen !== 1'b0 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL br_flush_raise: got flush=%b v=%b wen=%b ready=%b want 1/1/0/0", bus.flush, bus.commit_valid, bus.commit_wen, bus.alloc_ready); end
        tick();
        idle();
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.count !== 4'd0 || bus.alloc_tag !== 3'd0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL br_flush_after: got flush=%b count=%0d tag=%0d v=%b want 0/0/0/0", bus.flush, bus.count, bus.alloc_tag, bus.commit_valid); end
        bus.rd_tag = 3'd1;
        #1;
        checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL br_flush_cdb_dropped: got rd_ready=%b want 0", bus.rd_ready); end
`else
        checks++; if (bus.flush !== 1'b0 || bus.commit_valid !== 1'b1 || bus.commit_wen !== 1'b0 || bus.commit_tag !== 3'd0 || bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL br_retire: got flush=%b v=%b wen=%b tag=%0d ready=%b want 0/1/0/0/1", bus.flush, bus.commit_valid, bus.commit_wen, bus.commit_tag, bus.alloc_ready); end
        tick();
        idle();
        #1;
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 3'd1 || bus.commit_wen !== 1'b1 || bus.commit_data !== 16'h0077 || bus.commit_dest !== 4'd4 || bus.count !== 4'd2 || bus.flush !== 1'b0) begin errors++; $display("FAIL br_next: got v=%b tag=%0d wen=%b data=%h dest=%0d count=%0d flush=%b want 1/1/1/0077/4/2/0", bus.commit_valid, bus.commit_tag, bus.commit_wen, bus.commit_data, bus.commit_dest, bus.count, bus.flush); end
        tick();
        checks++; if (bus.count !== 4'd1 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL br_tail: got count=%0d v=%b want 1/0", bus.count, bus.commit_valid); end
`endif
    endtask

    // Operand lookup, ignored CDB writes, and reset in the middle of a run
    task automatic test_rd_lookup();
        apply_reset();
        bus.alloc_valid = 1'b1; bus.alloc_dest = 4'd1;
        tick();
        bus.alloc_dest = 4'd2;
        tick();
        idle();
        bus.rd_tag = 3'd1;
        #1;
        checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL rd_before_cdb: got %b want 0", bus.rd_ready); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd1; bus.cdb_data = 16'h00AB;
        #1;
        checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL rd_no_forward: got %b want 0", bus.rd_ready); end
        tick();
        idle();
        #1;
        checks++; if (bus.rd_ready !== 1'b1 || bus.rd_data !== 16'h00AB) begin errors++; $display("FAIL rd_after_cdb: got ready=%b data=%h want 1/00AB", bus.rd_ready, bus.rd_data); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd5; bus.cdb_data = 16'h00EE;
        tick();
        // CDB targets the tail being allocated in the same cycle
        bus.cdb_tag = 3'd2; bus.cdb_data = 16'h0099;
        bus.alloc_valid = 1'b1; bus.alloc_dest = 4'd3;
        #1;
        checks++; if (bus.alloc_tag !== 3'd2) begin errors++; $display("FAIL rd_alloc_tag: got %0d want 2", bus.alloc_tag); end
        tick();
        idle();
        bus.rd_tag = 3'd5;
        #1;
        checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL rd_idle_write: got %b want 0", bus.rd_ready); end
        bus.rd_tag = 3'd2;
        #1;
        checks++; if (bus.rd_ready !== 1'b0 || bus.count !== 4'd3) begin errors++; $display("FAIL rd_alloc_wins: got ready=%b count=%0d want 0/3", bus.rd_ready, bus.count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rd_tag = 3'd1;
        #1;
        checks++; if (bus.count !== 4'd0 || bus.rd_ready !== 1'b0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL rd_mid_reset: got count=%0d ready=%b v=%b want 0/0/0", bus.count, bus.rd_ready, bus.commit_valid); end
    endtask

    initial begin
        idle();
        bus.rd_tag = '0;
        test_reset();
        test_alloc_order();
        test_ooo_commit();
        test_full();
        test_wrap();
        test_branch();
        test_rd_lookup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
